// File: rtl/sprite_window_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : sprite_window_arbiter_if
// Brief    : Scan-position, next-id handshake and sprite-ROM bundle shared
//            by the window arbiter (slave) and its environment (master).
// Revision : 1.0 - initial release
// ============================================================================
interface sprite_window_arbiter_if;
    logic [10:0] col_addr_sig;
    logic [10:0] row_addr_sig;
    logic [2:0]  next_id;
    logic        next_id_valid;
    logic        next_id_ack;
    logic        banner_en;
    logic [14:0] rom_addr;
    logic        rom_data;
    logic        pix_on;
    logic [1:0]  pix_src;

    modport master (
        output col_addr_sig, row_addr_sig, next_id, next_id_valid, banner_en, rom_data,
        input  next_id_ack, rom_addr, pix_on, pix_src
    );

    modport slave (
        input  col_addr_sig, row_addr_sig, next_id, next_id_valid, banner_en, rom_data,
        output next_id_ack, rom_addr, pix_on, pix_src
    );
endinterface
`default_nettype wire

// File: rtl/sprite_window_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sprite_window_arbiter
// Brief    : Arbitrates the sprite ROM between the next-piece preview and the
//            banner window; optional banner blink via SPRITE_BLINK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sprite_window_arbiter #(
    parameter int PV_X0 = 100,
    parameter int PV_Y0 = 10,
    parameter int BN_X0 = 192,
    parameter int BN_Y0 = 200
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    sprite_window_arbiter_if.slave      bus
);

    localparam logic [10:0] c_PV_X0 = 11'(PV_X0);
    localparam logic [10:0] c_PV_Y0 = 11'(PV_Y0);
    localparam logic [10:0] c_BN_X0 = 11'(BN_X0);
    localparam logic [10:0] c_BN_Y0 = 11'(BN_Y0);
    localparam logic [11:0] c_PV_X1 = 12'(PV_X0 + 32);
    localparam logic [11:0] c_PV_Y1 = 12'(PV_Y0 + 32);
    localparam logic [11:0] c_BN_X1 = 12'(BN_X0 + 256);
    localparam logic [11:0] c_BN_Y1 = 12'(BN_Y0 + 32);
    localparam logic [2:0]  c_NO_PIECE = 3'd7;

    logic [2:0]  r_disp_id;
    logic [2:0]  r_shadow_id;
    logic        r_pending;
    logic        r_ack;
    logic [5:0]  r_frame_cnt;
    logic [14:0] r_rom_addr;
    logic [1:0]  r_tag;
    logic        r_pix_on;
    logic [1:0]  r_pix_src;

    logic        w_frame_start;
    logic        w_pv_hit;
    logic        w_bn_hit;
    logic        w_bn_act;
    logic [4:0]  w_pv_dx;
    logic [4:0]  w_pv_dy;
    logic [7:0]  w_bn_dx;
    logic [4:0]  w_bn_dy;
    logic [14:0] w_addr;
    logic [1:0]  w_tag;

    assign w_frame_start = (bus.row_addr_sig == 11'd0) && (bus.col_addr_sig == 11'd0);

`ifdef SPRITE_BLINK_EN
    assign w_bn_act = bus.banner_en & ~r_frame_cnt[5];
`else
    assign w_bn_act = bus.banner_en;
    logic w_unused_frame_cnt;
    assign w_unused_frame_cnt = ^r_frame_cnt;
`endif

    // Offsets are 11-bit differences truncated to the window's index width.
    assign w_pv_dx = 5'(bus.col_addr_sig - c_PV_X0);
    assign w_pv_dy = 5'(bus.row_addr_sig - c_PV_Y0);
    assign w_bn_dx = 8'(bus.col_addr_sig - c_BN_X0);
    assign w_bn_dy = 5'(bus.row_addr_sig - c_BN_Y0);

    assign w_pv_hit = (bus.col_addr_sig >= c_PV_X0) && ({1'b0, bus.col_addr_sig} < c_PV_X1)
                   && (bus.row_addr_sig >= c_PV_Y0) && ({1'b0, bus.row_addr_sig} < c_PV_Y1)
                   && (r_disp_id != c_NO_PIECE);
    assign w_bn_hit = (bus.col_addr_sig >= c_BN_X0) && ({1'b0, bus.col_addr_sig} < c_BN_X1)
                   && (bus.row_addr_sig >= c_BN_Y0) && ({1'b0, bus.row_addr_sig} < c_BN_Y1)
                   && w_bn_act;

    // Preview wins on overlap; base id*1024 and 8192 are pure bit concatenations.
    always_comb begin
        w_addr = '0;
        w_tag  = 2'd0;
        if (w_pv_hit) begin
            w_addr = {2'b00, r_disp_id, w_pv_dy, w_pv_dx};
            w_tag  = 2'd1;
        end else if (w_bn_hit) begin
            w_addr = {2'b01, w_bn_dy, w_bn_dx};
            w_tag  = 2'd2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rom_addr <= '0;
            r_tag      <= 2'd0;
            r_pix_on   <= 1'b0;
            r_pix_src  <= 2'd0;
        end else begin
            r_rom_addr <= w_addr;
            r_tag      <= w_tag;
            r_pix_on   <= (r_tag != 2'd0) & ~bus.rom_data;
            r_pix_src  <= r_tag;
        end
    end

    // Displayed id only changes at frame start so the preview never tears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp_id   <= c_NO_PIECE;
            r_shadow_id <= c_NO_PIECE;
            r_pending   <= 1'b0;
            r_ack       <= 1'b0;
            r_frame_cnt <= 6'd0;
        end else begin
            r_ack <= 1'b0;
            if (w_frame_start) begin
                r_frame_cnt <= r_frame_cnt + 6'd1;
            end
            if (w_frame_start && bus.next_id_valid) begin
                r_disp_id   <= bus.next_id;
                r_shadow_id <= bus.next_id;
                r_pending   <= 1'b0;
                r_ack       <= 1'b1;
            end else if (w_frame_start && r_pending) begin
                r_disp_id <= r_shadow_id;
                r_pending <= 1'b0;
                r_ack     <= 1'b1;
            end else if (bus.next_id_valid) begin
                r_shadow_id <= bus.next_id;
                r_pending   <= 1'b1;
            end
        end
    end

    assign bus.rom_addr    = r_rom_addr;
    assign bus.pix_on      = r_pix_on;
    assign bus.pix_src     = r_pix_src;
    assign bus.next_id_ack = r_ack;

endmodule
`default_nettype wire

// File: tb/tb_sprite_window_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_window_arbiter
// Brief    : Directed self-checking bench for sprite_window_arbiter; the
//            ROM model returns rom_addr[0] as the pixel data bit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_window_arbiter;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fails;

    sprite_window_arbiter_if bus ();

    sprite_window_arbiter #(
        .PV_X0 (100),
        .PV_Y0 (10),
        .BN_X0 (192),
        .BN_Y0 (200)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    assign bus.rom_data = bus.rom_addr[0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scan(input int c, input int r);
        bus.col_addr_sig = 11'(c);
        bus.row_addr_sig = 11'(r);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_n    = 1'b0;
        scan(5, 5);
        bus.next_id       = 3'd0;
        bus.next_id_valid = 1'b0;
        bus.banner_en     = 1'b0;
        repeat (2) step();
        check("rst_rom_addr", 32'(bus.rom_addr), 0);
        check("rst_pix_on", 32'(bus.pix_on), 0);
        check("rst_pix_src", 32'(bus.pix_src), 0);
        check("rst_ack", 32'(bus.next_id_ack), 0);
        rst_n = 1'b1;

        // id 3 offered mid-frame, committed at frame start
        bus.next_id_valid = 1'b1; bus.next_id = 3'd3;
        step();
        bus.next_id_valid = 1'b0;
        check("t1_no_early_ack", 32'(bus.next_id_ack), 0);
        scan(0, 0);
        step();
        check("t1_ack", 32'(bus.next_id_ack), 1);
        scan(100, 10);
        step();
        check("t1_ack_single", 32'(bus.next_id_ack), 0);
        check("t1_rom_addr", 32'(bus.rom_addr), 3072);
        step();
        check("t1_pix_src", 32'(bus.pix_src), 1);
        check("t1_pix_on", 32'(bus.pix_on), 1);

        // id 2, bottom-right preview pixel
        scan(50, 50); bus.next_id_valid = 1'b1; bus.next_id = 3'd2;
        step();
        bus.next_id_valid = 1'b0;
        scan(0, 0);
        step();
        check("t2_ack", 32'(bus.next_id_ack), 1);
        scan(131, 41);
        step();
        check("t2_rom_addr", 32'(bus.rom_addr), 3071);
        scan(132, 10);
        step();
        check("t2_pix_src", 32'(bus.pix_src), 1);
        check("t2_pix_on", 32'(bus.pix_on), 0);
        check("t2_col132_outside", 32'(bus.rom_addr), 0);

        // banner corners and right edge
        bus.banner_en = 1'b1;
        scan(192, 200);
        step();
        check("t3_bn_first", 32'(bus.rom_addr), 8192);
        scan(447, 231);
        step();
        check("t3_bn_last", 32'(bus.rom_addr), 16383);
        check("t3_src_first", 32'(bus.pix_src), 2);
        check("t3_on_first", 32'(bus.pix_on), 1);
        scan(448, 231);
        step();
        check("t3_col448_addr", 32'(bus.rom_addr), 0);
        check("t3_src_last", 32'(bus.pix_src), 2);
        check("t3_on_last", 32'(bus.pix_on), 0);
        step();
        check("t3_col448_src", 32'(bus.pix_src), 0);
        check("t3_col448_on", 32'(bus.pix_on), 0);

        // latest-wins shadow, then a valid exactly at frame start
        bus.banner_en = 1'b0;
        scan(20, 20); bus.next_id_valid = 1'b1; bus.next_id = 3'd5;
        step();
        check("t4_ack_a", 32'(bus.next_id_ack), 0);
        bus.next_id = 3'd1;
        step();
        check("t4_ack_b", 32'(bus.next_id_ack), 0);
        scan(0, 0); bus.next_id = 3'd4;
        step();
        bus.next_id_valid = 1'b0;
        check("t4_ack", 32'(bus.next_id_ack), 1);
        scan(100, 10);
        step();
        check("t4_ack_single", 32'(bus.next_id_ack), 0);
        check("t4_rom_addr", 32'(bus.rom_addr), 4096);

        // id 7 blanks the preview; frame start without pending gives no ack
        scan(20, 20); bus.next_id_valid = 1'b1; bus.next_id = 3'd7;
        step();
        bus.next_id_valid = 1'b0;
        scan(0, 0);
        step();
        check("t5_ack", 32'(bus.next_id_ack), 1);
        step();
        check("t5_no_pending_ack", 32'(bus.next_id_ack), 0);
        scan(110, 20);
        step();
        check("t5_rom_addr", 32'(bus.rom_addr), 0);
        step();
        check("t5_pix_src", 32'(bus.pix_src), 0);
        check("t5_pix_on", 32'(bus.pix_on), 0);

`ifdef SPRITE_BLINK_EN
        // five frame starts so far; advance to frame 31, then into 32
        bus.banner_en = 1'b1;
        scan(0, 0);
        repeat (26) step();
        scan(192, 200);
        step();
        check("blink_frame31_on", 32'(bus.rom_addr), 8192);
        scan(0, 0);
        step();
        scan(192, 200);
        step();
        check("blink_frame32_off", 32'(bus.rom_addr), 0);
`endif

        // asynchronous reset in the middle of a banner scan
        bus.banner_en = 1'b1;
        scan(192, 200);
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_pix_on", 32'(bus.pix_on), 0);
        check("rst_mid_rom_addr", 32'(bus.rom_addr), 0);
        step();
        check("rst_mid_pix_on_next", 32'(bus.pix_on), 0);
        check("rst_mid_pix_src_next", 32'(bus.pix_src), 0);
        rst_n = 1'b1;
        step();
        check("rst_bn_restart", 32'(bus.rom_addr), 8192);
        scan(100, 10);
        step();
        check("rst_bn_src", 32'(bus.pix_src), 2);
        check("rst_disp_id_blank", 32'(bus.rom_addr), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sprite_window_arbiter.md
# sprite_window_arbiter

Shares the single synchronous sprite ROM between the two on-screen bitmap windows of the VGA tetris display: the next-piece preview and the title/game-over banner. Every pixel clock it decides which window, if any, owns the current scan position. It generates the ROM address for that window and realigns the 1-bit ROM data into a registered pixel enable for the colour mux. It also double-buffers the next-piece identifier so the preview only changes at frame start, which prevents tearing.

## Interface
Parameters:
- PV_X0, 100: preview window left column (inclusive)
- PV_Y0, 10: preview window top row (inclusive)
- BN_X0, 192: banner window left column
- BN_Y0, 200: banner window top row

Ports:
- clk  in  1  pixel clock; one clock domain only
- rst_n  in  1  asynchronous, active-low reset
- col_addr_sig  in  11  current scan column
- row_addr_sig  in  11  current scan row
- next_id  in  3  next piece index 0..6; 7 means no piece
- next_id_valid  in  1  next_id is offered this cycle
- next_id_ack  out  1  one-cycle pulse when the offered id is committed to the display
- banner_en  in  1  level input; banner is shown while high
- rom_addr  out  15  address to the sprite ROM (ROM read latency is 1 clock)
- rom_data  in  1  ROM output; 0 means foreground (lit)
- pix_on  out  1  pixel lit, aligned to the pixel 2 clocks earlier
- pix_src  out  2  source of pix_on: 0 none, 1 preview, 2 banner

## Operation
- Preview window: 32x32 pixels at (PV_X0, PV_Y0). ROM base = id*1024. Address = base + (row-PV_Y0)*32 + (col-PV_X0).
- Banner window: 256x32 pixels at (BN_X0, BN_Y0). ROM base = 8192. Address = 8192 + (row-BN_Y0)*256 + (col-BN_X0).
- Window bounds are half-open, e.g. PV_X0 <= col < PV_X0+32. Subtractions are done at 11 bits; only the low 5 or 8 bits enter the address. The multiplies are shifts.
- Priority when the two windows overlap: preview over banner.
- The preview window is inactive when the displayed id is 7.
- The banner window is inactive when banner_en is 0.
- When no window is active: rom_addr is 0 and the window tag is 0.
- Stage 1 registers rom_addr and the tag. Stage 2 registers:
  - pix_on = (tag != 0) & ~rom_data
  - pix_src = tag
- Next-id handshake:
  - next_id_valid=1 loads the shadow register and sets pending. A later valid overwrites the shadow (latest wins).
  - Frame start is the cycle where row_addr_sig==0 and col_addr_sig==0. At frame start, if pending, the shadow is copied to the displayed id, pending is cleared, and next_id_ack=1 for that cycle.
  - If valid and frame start occur in the same cycle, the incoming next_id is committed directly and acked.
  - next_id_ack stays 0 whenever pending is 0.
- Frame counter: 6 bits, increments at every frame start, wraps from 63 to 0.

## Timing
- Latency from col/row to pix_on/pix_src: exactly 2 clocks.
- A displayed-id change affects rom_addr on the clock after the frame-start cycle.
- Reset values:
  - rom_addr=0, pix_on=0, pix_src=0, next_id_ack=0
  - displayed id=7 (preview blank), shadow=7, pending=0, frame counter=0
- Reset asserted mid-frame clears all state immediately. Pipeline contents are discarded and pix_on is 0 on the next clock.
- Scan inputs are sampled every clock. No stall exists.

## Configuration
- SPRITE_BLINK_EN defined: banner is active only when banner_en=1 and frame counter bit 5 is 0. This gives 32 frames on, 32 frames off.
- SPRITE_BLINK_EN undefined: banner follows banner_en only. The frame counter is still built but is unused.

## Test plan
- Reset, then next_id=3 with valid for 1 clock mid-frame, then run to frame start. Required: next_id_ack pulses exactly once at row=0/col=0. Scan (col=100, row=10) then gives rom_addr=3072 one clock later.
- Displayed id=2, scan (col=131, row=41). Required: rom_addr=2048+31*32+31=3071. pix_src=1 two clocks after the input. pix_on = ~rom_data.
- banner_en=1, scan (col=192, row=200) then (col=447, row=231). Required: rom_addr=8192, then 16383. Column 448 gives rom_addr=0 and pix_src=0.
- Valid id=5 and then id=1 before frame start, then valid id=4 asserted exactly at the frame-start cycle. Required: displayed id becomes 4 and a single ack is issued.
- Displayed id=7, scan inside the preview window. Required: pix_src=0 and pix_on=0.
- With SPRITE_BLINK_EN defined: banner visible for frames 0-31 and blank for frames 32-63. Assert rst_n=0 mid-frame. Required: pix_on=0 on the next clock and frame count restarts at 0.
